// File: rtl/alu_sched.sv
// alu_sched: two-port valid/ready front end that shares one combinational alu.
// One op is in flight at a time: IDLE (arbitrate/accept) -> EXEC (alu) -> RESP
// (hold until taken). The response carries the id of the requester it belongs to.

// Combinational 32-bit alu.
// Opcodes: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 pass-b; others give 0.
module alu_sched_alu (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  output logic [31:0] out_o
);
  // opcode decode, 32-bit wrap-around arithmetic
  always_comb begin
    out_o = '0;
    case (op_i)
      4'b0000: out_o = a_i & b_i;
      4'b0001: out_o = a_i | b_i;
      4'b0010: out_o = a_i + b_i;
      4'b0110: out_o = a_i - b_i;
      4'b0111: out_o = b_i;
      default: out_o = '0;
    endcase
  end
endmodule

module alu_sched #(
  parameter bit RR_EN      = 1'b1,  // 1: round-robin, 0: port 0 always wins
  parameter bit ILLEGAL_OK = 1'b0   // 1: unknown opcodes run as pass-b
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        id;
  } opnd_t;

  localparam logic [3:0] OP_PASSB = 4'b0111;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  state_e      state_q;
  opnd_t       opnd_q;
  opnd_t       req_sel;
  logic        last_q;        // id of the most recently accepted port
  logic        grant_id;
  logic        accept;
  logic        exec_legal;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic        rsp_zero_q;
  logic        rsp_err_q;
  logic [31:0] rsp_result_q;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;

  // Arbitration winner; only meaningful when at least one valid is high.
  // A lone valid port always wins; a tie goes to the port not granted last.
  always_comb begin
    grant_id = req1_valid;
    if (req0_valid && req1_valid) grant_id = RR_EN ? ~last_q : 1'b0;
  end

  // ready depends only on state and the valids, never on the response side
  assign req0_ready = (state_q == IDLE) && req0_valid && !grant_id;
  assign req1_ready = (state_q == IDLE) && req1_valid &&  grant_id;
  assign accept     = req0_ready || req1_ready;

  // Operands of the winning port; tolerated unknown opcodes are remapped here
  always_comb begin
    req_sel.id = grant_id;
    req_sel.a  = grant_id ? req1_a  : req0_a;
    req_sel.b  = grant_id ? req1_b  : req0_b;
    req_sel.op = grant_id ? req1_op : req0_op;
    if (ILLEGAL_OK && !op_legal(req_sel.op)) req_sel.op = OP_PASSB;
  end

  assign exec_legal = op_legal(opnd_q.op);

  // The alu sees operands only in EXEC with a legal opcode, otherwise it rests at zero
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (state_q == EXEC && exec_legal) begin
      alu_a  = opnd_q.a;
      alu_b  = opnd_q.b;
      alu_op = opnd_q.op;
    end
  end

  alu_sched_alu u_alu (
    .a_i   (alu_a),
    .b_i   (alu_b),
    .op_i  (alu_op),
    .out_o (alu_out)
  );

  // Control FSM with registered response; zero flag is derived here, not by the alu
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      opnd_q       <= '0;
      last_q       <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            opnd_q  <= req_sel;
            last_q  <= grant_id;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= opnd_q.id;
          if (exec_legal) begin
            rsp_result_q <= alu_out;
            rsp_zero_q   <= (alu_out == '0);
            rsp_err_q    <= 1'b0;
          end else begin
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b1;
            rsp_err_q    <= 1'b1;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != IDLE);

endmodule
